// File: rtl/mips_multicycle.sv
// Multicycle MIPS core: one shared memory port serves fetch and data, and an FSM sequences
// each instruction through 3-5 states. An illegal opcode or funct parks the core in HALT until reset.
module mips_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic              retire,
  output logic [3:0]        dbg_state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic [31:0] rf_q [32];

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] addr_full;
  logic [2:0]  alu_ctl;
  logic        funct_ok;

  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [31:0] signimm;
  logic        unused_shamt;

  assign op           = ir_q[31:26];
  assign rs           = ir_q[25:21];
  assign rt           = ir_q[20:16];
  assign rd           = ir_q[15:11];
  assign funct        = ir_q[5:0];
  assign signimm      = {{16{ir_q[15]}}, ir_q[15:0]};
  assign unused_shamt = ^ir_q[10:6];

  function automatic logic [31:0] alu(input logic [2:0] ctl, input logic [31:0] x,
                                      input logic [31:0] y);
    case (ctl)
      ALU_ADD: alu = x + y;
      ALU_SUB: alu = x - y;
      ALU_AND: alu = x & y;
      ALU_OR:  alu = x | y;
      ALU_SLT: alu = {31'd0, $signed(x) < $signed(y)};
      default: alu = x + y;
    endcase
  endfunction

  always_comb begin
    alu_ctl  = ALU_ADD;
    funct_ok = 1'b1;
    case (funct)
      6'h20:   alu_ctl = ALU_ADD;
      6'h22:   alu_ctl = ALU_SUB;
      6'h24:   alu_ctl = ALU_AND;
      6'h25:   alu_ctl = ALU_OR;
      6'h2A:   alu_ctl = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic; memory states advance only on the cycle mem_ready completes the access
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = funct_ok ? S_EXEC : S_HALT;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_HALT;
        endcase
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  // Memory handshake: a request is held (addr/we/wdata unchanged) from the cycle mem_req rises
  // until the cycle mem_ready=1, which completes it; mem_ready is don't-care while mem_req=0.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_full = pc_q;
    retire    = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_FETCH: mem_req = 1'b1;
      S_MEMRD: begin
        mem_req   = 1'b1;
        addr_full = alu_out_q;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        addr_full = alu_out_q;
        retire    = mem_ready;
      end
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: retire = 1'b1;
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
    // Reset drops the request combinationally, abandoning any access in flight
    mem_req = mem_req & reset;
    mem_we  = mem_we & reset;
    retire  = retire & reset;
  end

  assign mem_addr  = addr_full[ADDR_W-1:0];
  assign mem_wdata = b_q;
  assign dbg_state = state_q;

  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    mdr_d     = mdr_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    rf_we     = 1'b0;
    rf_waddr  = rt;
    rf_wdata  = alu_out_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_d = mem_rdata;
          pc_d = pc_q + 32'd4;
        end
      end
      S_DECODE: begin
        a_d       = (rs == 5'd0) ? 32'd0 : rf_q[rs];
        b_d       = (rt == 5'd0) ? 32'd0 : rf_q[rt];
        alu_out_d = pc_q + {signimm[29:0], 2'b00};
      end
      S_MEMADR, S_ADDIEX: alu_out_d = a_q + signimm;
      S_MEMRD:  if (mem_ready) mdr_d = mem_rdata;
      S_MEMWB: begin
        rf_we    = 1'b1;
        rf_wdata = mdr_q;
      end
      S_EXEC:   alu_out_d = alu(alu_ctl, a_q, b_q);
      S_ALUWB: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
      end
      S_ADDIWB: rf_we = 1'b1;
      S_BRANCH: if (a_q == b_q) pc_d = alu_out_q;
      // PC already holds PC+4 here, so the upper nibble comes from the next sequential address
      S_JUMP:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      mdr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mdr_q     <= mdr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_mips_multicycle.sv
// Bench for mips_multicycle: programs run against an ISA-level interpreter that predicts the
// bus transaction stream, per-instruction cycle counts and stored register values.
module tb_mips_multicycle;

  localparam logic [31:0] RPC  = 32'h0000_0100;
  localparam logic [31:0] ILL  = 32'hFC00_0000;
  localparam logic [31:0] DUMP = 32'h0000_0300;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req, mem_we, halted, retire;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [3:0]  dbg_state;

  mips_multicycle #(.RESET_PC(RPC), .ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .halted    (halted),
    .retire    (retire),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // memory image and program builder
  logic [31:0] mem [0:1023];
  logic [31:0] pa;

  function automatic logic [31:0] rdm(input logic [31:0] a);
    return mem[a[11:2]];
  endfunction

  task automatic emit(input logic [31:0] ins);
    mem[pa[11:2]] = ins;
    pa = pa + 32'd4;
  endtask

  function automatic logic [31:0] enc_r(input int fn, input int rd, input int rs, input int rt);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] target);
    return {6'h02, target[27:2]};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = ILL;
    for (int i = 128; i < 192; i++) mem[i] = $urandom;
    for (int i = 192; i < 200; i++) mem[i] = 32'hAAAA_AAAA;
    pa = RPC;
  endtask

  task automatic emit_dump();
    for (int r = 1; r < 8; r++) emit(enc_i('h2B, 0, r, 'h300 + 4 * r));
  endtask

  // reference interpreter
  logic [64:0] exp_q[$];
  int          exp_cpi_q[$];
  int          model_n, model_cyc;
  logic [31:0] mm   [0:1023];
  logic [31:0] mreg [0:31];

  task automatic model_run();
    logic [31:0] pc, ins, imm, ea, v;
    int rs, rt, rd, cpi;
    bit stop;
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    for (int i = 0; i < 1024; i++) mm[i] = mem[i];
    exp_q.delete();
    exp_cpi_q.delete();
    model_n = 0;
    model_cyc = 0;
    pc = RPC;
    stop = 0;
    for (int n = 0; n < 4000 && !stop; n++) begin
      ins = mm[pc[11:2]];
      exp_q.push_back({1'b0, pc, 32'd0});
      pc  = pc + 32'd4;
      imm = {{16{ins[15]}}, ins[15:0]};
      rs  = int'(ins[25:21]);
      rt  = int'(ins[20:16]);
      rd  = int'(ins[15:11]);
      cpi = 0;
      case (ins[31:26])
        6'h00: begin
          v = '0;
          case (ins[5:0])
            6'h20: v = mreg[rs] + mreg[rt];
            6'h22: v = mreg[rs] - mreg[rt];
            6'h24: v = mreg[rs] & mreg[rt];
            6'h25: v = mreg[rs] | mreg[rt];
            6'h2A: v = ($signed(mreg[rs]) < $signed(mreg[rt])) ? 32'd1 : 32'd0;
            default: stop = 1;
          endcase
          if (!stop) begin
            if (rd != 0) mreg[rd] = v;
            cpi = 4;
          end
        end
        6'h23: begin
          ea = mreg[rs] + imm;
          exp_q.push_back({1'b0, ea, 32'd0});
          if (rt != 0) mreg[rt] = mm[ea[11:2]];
          cpi = 5;
        end
        6'h2B: begin
          ea = mreg[rs] + imm;
          exp_q.push_back({1'b1, ea, mreg[rt]});
          mm[ea[11:2]] = mreg[rt];
          cpi = 4;
        end
        6'h04: begin
          if (mreg[rs] == mreg[rt]) pc = pc + (imm << 2);
          cpi = 3;
        end
        6'h08: begin
          if (rt != 0) mreg[rt] = mreg[rs] + imm;
          cpi = 4;
        end
        6'h02: begin
          pc  = {pc[31:28], ins[25:0], 2'b00};
          cpi = 3;
        end
        default: stop = 1;
      endcase
      if (!stop) begin
        exp_cpi_q.push_back(cpi);
        model_n++;
        model_cyc += cpi;
      end
    end
  endtask

  // memory responder, bus scoreboard and cycle accounting
  int   wmode = 1;
  int   wfix = 0;
  bit   counting = 0;
  int   cyc_inst, stall_inst, stall_total, cyc_total, retires;

  function automatic int pick_wait(input logic we, input logic [31:0] a);
    if (wmode == 2) return (!we && a[31:8] == 24'h000002) ? 100000 : 0;
    if (wmode == 1) return wfix;
    return int'($urandom_range(0, 3));
  endfunction

  initial begin
    bit          pend;
    int          wleft;
    logic        h_we;
    logic [31:0] h_addr, h_wdata;
    logic [64:0] e;
    pend = 0;
    wleft = 0;
    forever begin
      @(negedge clk);
      if (!reset || !mem_req) begin
        pend      = 0;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end else begin
        if (!pend) begin
          pend    = 1;
          wleft   = pick_wait(mem_we, mem_addr);
          h_addr  = mem_addr;
          h_we    = mem_we;
          h_wdata = mem_wdata;
        end else begin
          check("hold_addr", mem_addr, h_addr);
          check("hold_we", {31'd0, mem_we}, {31'd0, h_we});
          if (h_we) check("hold_wdata", mem_wdata, h_wdata);
        end
        if (wleft > 0) begin
          wleft--;
          mem_ready = 1'b0;
          mem_rdata = $urandom;
          stall_inst++;
          stall_total++;
        end else begin
          pend      = 0;
          mem_ready = 1'b1;
          mem_rdata = mem[mem_addr[11:2]];
          if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
          if (exp_q.size() > 0) e = exp_q.pop_front();
          else e = {~mem_we, ~mem_addr, 32'd0};
          check("bus_addr", mem_addr, e[63:32]);
          check("bus_we", {31'd0, mem_we}, {31'd0, e[64]});
          if (e[64]) check("bus_wdata", mem_wdata, e[31:0]);
        end
      end
      #2;
      if (reset && !halted && counting) begin
        cyc_inst++;
        cyc_total++;
        if (retire) begin
          retires++;
          check("cpi", cyc_inst,
                (exp_cpi_q.size() > 0 ? exp_cpi_q.pop_front() : -100) + stall_inst);
          cyc_inst   = 0;
          stall_inst = 0;
        end
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(posedge clk);
    #2;
    reset    = 1'b0;
    counting = 0;
    #1;
    check("rst_req", {31'd0, mem_req}, 0);
    check("rst_halted", {31'd0, halted}, 0);
    check("rst_retire", {31'd0, retire}, 0);
    repeat (2) @(posedge clk);
    #2;
    cyc_inst    = 0;
    stall_inst  = 0;
    stall_total = 0;
    cyc_total   = 0;
    retires     = 0;
    reset       = 1'b1;
    counting    = 1;
    #1;
    check("first_req", {31'd0, mem_req}, 1);
    check("first_addr", mem_addr, RPC);
    check("first_halted", {31'd0, halted}, 0);
  endtask

  task automatic run_prog(input string name);
    int n;
    model_run();
    do_reset();
    n = 0;
    while (!halted && n < 4000) begin
      @(posedge clk);
      #2;
      n++;
    end
    check({name, "_halted"}, {31'd0, halted}, 1);
    check({name, "_busq"}, exp_q.size(), 0);
    check({name, "_cpiq"}, exp_cpi_q.size(), 0);
    check({name, "_retires"}, retires, model_n);
    check({name, "_cycles"}, cyc_total, model_cyc + 2 + stall_total);
  endtask

  task automatic gen_random();
    int k;
    int fns [5] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A};
    for (int i = 0; i < 30; i++) begin
      k = int'($urandom_range(0, 9));
      case (k)
        3: emit(enc_i('h08, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535)));
        4: emit(enc_i('h23, 0, $urandom_range(0, 7), 'h200 + 4 * $urandom_range(0, 63)));
        5: emit(enc_i('h2B, 0, $urandom_range(0, 7), 'h200 + 4 * $urandom_range(0, 63)));
        6: emit(enc_i('h04, $urandom_range(1, 7), $urandom_range(1, 7), $urandom_range(0, 1)));
        7: emit(enc_j(pa + 32'd8));
        default: emit(enc_r(fns[$urandom_range(0, 4)], $urandom_range(0, 7),
                            $urandom_range(0, 7), $urandom_range(0, 7)));
      endcase
    end
    emit(enc_i('h08, 0, 0, 0));
    emit_dump();
    emit(ILL);
  endtask

  initial begin
    int n;
    // arithmetic, zero wait states
    wmode = 1;
    wfix  = 0;
    clear_mem();
    emit(enc_i('h08, 0, 1, 5));
    emit(enc_i('h08, 0, 2, -3));
    emit(enc_r('h20, 3, 1, 2));
    emit(enc_r('h22, 4, 2, 1));
    emit(enc_r('h2A, 5, 2, 1));
    emit_dump();
    emit(ILL);
    run_prog("arith");
    check("arith_r3", rdm(DUMP + 12), 32'd2);
    check("arith_r4", rdm(DUMP + 16), 32'hFFFF_FFF8);
    check("arith_r5", rdm(DUMP + 20), 32'd1);

    // store/load with two wait states on every access
    wfix = 2;
    clear_mem();
    emit(enc_i('h08, 0, 3, 2));
    emit(enc_i('h2B, 0, 3, 8));
    emit(enc_i('h23, 0, 6, 8));
    emit_dump();
    emit(ILL);
    run_prog("memwait");
    check("memwait_word8", rdm(32'h8), 32'd2);
    check("memwait_r6", rdm(DUMP + 24), 32'd2);

    // branches and jumps, random wait states
    wmode = 0;
    clear_mem();
    emit(enc_i('h08, 0, 1, 1));
    emit(enc_i('h08, 0, 2, 2));
    emit(enc_j(32'h20));
    pa = 32'h20;
    emit(enc_i('h04, 1, 2, 3));
    emit(enc_i('h08, 2, 2, -1));
    emit(enc_i('h04, 1, 2, -3));
    pa = 32'h30;
    emit(enc_j(32'h140));
    pa = 32'h140;
    emit_dump();
    emit(ILL);
    run_prog("branch");
    check("branch_r2", rdm(DUMP + 8), 32'd1);

    // $0 stays zero
    clear_mem();
    emit(enc_i('h08, 0, 1, 9));
    emit(enc_i('h08, 0, 0, 7));
    emit(enc_r('h20, 1, 0, 0));
    emit_dump();
    emit(ILL);
    run_prog("zero");
    check("zero_r1", rdm(DUMP + 4), 32'd0);

    // illegal opcode halts until reset
    clear_mem();
    run_prog("halt");
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (mem_req || retire) n++;
    end
    check("halt_quiet", n, 0);
    check("halt_stays", {31'd0, halted}, 1);
    do_reset();

    // unlisted R-type funct halts
    clear_mem();
    emit(enc_i('h08, 0, 1, 3));
    emit(enc_r('h21, 2, 1, 1));
    run_prog("badfunct");

    // randomized programs
    for (int p = 0; p < 6; p++) begin
      clear_mem();
      gen_random();
      run_prog("rand");
    end

    // reset during a stalled load
    wmode = 2;
    clear_mem();
    emit(enc_i('h08, 0, 6, 9));
    emit(enc_i('h23, 0, 6, 'h200));
    emit_dump();
    emit(ILL);
    model_run();
    do_reset();
    n = 0;
    while (!(mem_req && !mem_we && mem_addr == 32'h200) && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("rdstall_reach", mem_addr, 32'h200);
    repeat (3) @(posedge clk);
    #2;
    check("rdstall_req", {31'd0, mem_req}, 1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    counting = 0;
    #1;
    check("rdstall_drop", {31'd0, mem_req}, 0);
    wmode = 0;
    clear_mem();
    emit_dump();
    emit(ILL);
    run_prog("after_abort");
    check("after_abort_r6", rdm(DUMP + 24), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle.md
# mips_multicycle

Multicycle MIPS core that succeeds the single-cycle datapath. One 32-bit memory port is shared by instruction fetch and data access, and a control FSM steps each instruction through 3–5 states. The block adds a ready-handshake memory interface with wait-state stalling, a parametrised reset vector and address width, and a halt-on-illegal-opcode mode. It sits between the top level and a unified instruction/data memory.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- ADDR_W, 32, memory address width; mem_addr = low ADDR_W bits of the byte address
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- mem_req  out  1  memory access request this cycle
- mem_we  out  1  1 = write, 0 = read; valid only while mem_req=1
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  32  store data (rt register value)
- mem_rdata  in  32  read data; sampled in the cycle mem_ready=1
- mem_ready  in  1  access completes in the cycle it is high while mem_req=1
- halted  out  1  illegal opcode seen; core stopped
- retire  out  1  one-cycle pulse in the final cycle of each instruction

## Operation
- Instruction set: R-type funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A; lw 0x23; sw 0x2B; beq 0x04; addi 0x08; j 0x02.
- Any other opcode, or an unlisted R-type funct, sends the FSM to HALT.
- Internal registers: PC, IR, MDR, A, B, ALUOut; 32×32 register file with 2 read ports and 1 write port.
- Register $0 reads as 0; writes to $0 are discarded.
- ALU uses the 3-bit codes add 010, sub 110, and 000, or 001, slt 111.
- slt is a signed compare. Arithmetic wraps mod 2^32 with no overflow trap. The immediate is sign-extended.
- FSM states and transitions:
  - FETCH: mem_req=1, mem_addr=PC. Stay while mem_ready=0. On mem_ready, latch IR and set PC←PC+4, then go to DECODE.
  - DECODE: read rs/rt into A/B and set ALUOut←PC+(signimm<<2). Next state by opcode: lw/sw→MEMADR, R→EXEC, beq→BRANCH, addi→ADDIEX, j→JUMP, else→HALT.
  - MEMADR: ALUOut←A+signimm. lw→MEMRD, sw→MEMWR.
  - MEMRD: mem_req=1, mem_we=0, addr=ALUOut. Wait for mem_ready, latch MDR, then go to MEMWB.
  - MEMWB: rt←MDR, retire, then FETCH.
  - MEMWR: mem_req=1, mem_we=1, addr=ALUOut, wdata=B. Wait for mem_ready, retire, then FETCH.
  - EXEC: ALUOut←A op B, then ALUWB. ALUWB: rd←ALUOut, retire, then FETCH.
  - ADDIEX: ALUOut←A+signimm, then ADDIWB. ADDIWB: rt←ALUOut, retire, then FETCH.
  - BRANCH: if A==B then PC←ALUOut. Retire, then FETCH.
  - JUMP: PC←{PC[31:28], IR[25:0], 2'b00}. Retire, then FETCH.
  - HALT: halted=1 and mem_req=0 permanently. Only reset exits HALT.
- mem_addr, mem_we and mem_wdata hold stable for as long as mem_req=1 and mem_ready=0.

## Timing
- Reset values: PC=RESET_PC, state FETCH, IR/MDR/A/B/ALUOut=0, register file=0, halted=0, retire=0.
- mem_req is forced to 0 while reset=0. mem_req rises in the first cycle after reset deasserts.
- With zero wait states, cycles per instruction are: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each cycle with mem_ready=0 during FETCH, MEMRD or MEMWR adds 1 cycle.
- mem_ready is ignored while mem_req=0.
- Register file write happens on the clock edge that ends the writeback state. A read in the following DECODE returns the new value.
- Reset asserted mid-access drops mem_req immediately and abandons the instruction. The partial instruction leaves no register file update.
- PC wraps from 0xFFFF_FFFC to 0. The jump target takes its upper 4 bits from PC+4.

## Test plan
- Reset with RESET_PC=0x100, memory ready every cycle -> first mem_addr=0x100; the second fetch occurs at cycle 5 of an R-type, with addr 0x104.
- Program addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; sub $4,$2,$1; slt $5,$2,$1 -> $3=2, $4=0xFFFF_FFF8, $5=1; retire pulses at cycles 4, 8, 12, 16, 20.
- sw $3,8($0) then lw $6,8($0), with mem_ready low for 2 cycles on every access -> write of addr 8, data 2; $6=2. sw takes 8 cycles and lw takes 9 (one 2-cycle wait each in FETCH, MEMWR/MEMRD).
- beq $1,$1,-1 at 0x20 -> next fetch at 0x20; beq $1,$2,+3 at 0x20 -> next fetch at 0x24. j 0x40 at 0x30 -> next fetch at 0x100.
- Opcode 0x3F -> halted=1 after DECODE; mem_req stays 0 for 100 cycles. reset low then high -> fetch resumes at RESET_PC with halted=0.
- addi $0,$0,7 then add $1,$0,$0 -> $1=0. Reset pulsed during a stalled MEMRD -> mem_req drops in the same cycle and the target register is unchanged.
